// File: rtl/sdram_arbiter_if.sv
// Channel-side and controller-side signal bundle for the SDRAM arbiter.
// The arbiter takes the slave view. The requesters and the controller model take the master view.
interface sdram_arbiter_if #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CH-1:0]                 ch_req;
    logic [NUM_CH-1:0]                 ch_we;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0]                 ch_busy;
    logic [NUM_CH-1:0]                 ch_ack;
    logic                              ch_err;
    logic [DATA_WIDTH-1:0]             ch_rdata;
    logic [NUM_CH-1:0]                 overrun;
    logic                              mem_req;
    logic                              mem_we;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              mem_ack;
    logic [DATA_WIDTH-1:0]             mem_rdata;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, mem_ack, mem_rdata,
        output ch_busy, ch_ack, ch_err, ch_rdata, overrun,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, mem_ack, mem_rdata,
        input  ch_busy, ch_ack, ch_err, ch_rdata, overrun,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller port between NUM_CH requesters.
// It latches request pulses per channel, issues one access at a time, and aborts when an ack is lost.
module sdram_arbiter_ch #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  clr_i,
    output logic                  pend_o,
    output logic                  pend_eff_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  ovr_o
);
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cap;

    assign cap = req_i & ~pend_q;

    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovr_d   = ovr_q | (req_i & pend_q);
        if (cap) begin
            pend_d  = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A request captured this cycle is visible to the arbiter immediately, so IDLE can issue it next cycle.
    assign pend_o     = pend_q;
    assign pend_eff_o = pend_q | cap;
    assign we_o       = cap ? we_i    : we_q;
    assign addr_o     = cap ? addr_i  : addr_q;
    assign wdata_o    = cap ? wdata_i : wdata_q;
    assign ovr_o      = ovr_q;
endmodule

module sdram_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sdram_arbiter_if.slave bus
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } acc_t;

    logic [NUM_CH-1:0]                 pend, pend_eff, ovr, eff_we;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] eff_addr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] eff_wdata;

    logic [0:0]            state_q, state_d;
    logic [GW-1:0]         last_q, last_d, gnt_q, gnt_d, rr_idx;
    logic                  rr_found;
    logic [7:0]            wd_q, wd_d;
    logic                  mreq_q, mreq_d;
    acc_t                  mem_q, mem_d;
    logic [NUM_CH-1:0]     ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    int                    j;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            sdram_arbiter_ch #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_ch (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .req_i      (bus.ch_req[i]),
                .we_i       (bus.ch_we[i]),
                .addr_i     (bus.ch_addr[i]),
                .wdata_i    (bus.ch_wdata[i]),
                .clr_i      (ack_d[i]),
                .pend_o     (pend[i]),
                .pend_eff_o (pend_eff[i]),
                .we_o       (eff_we[i]),
                .addr_o     (eff_addr[i]),
                .wdata_o    (eff_wdata[i]),
                .ovr_o      (ovr[i])
            );
        end
    endgenerate

    // Search starts just after the last grant, so every pending channel is served within NUM_CH-1 other grants.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            j = (int'(last_q) + k) % NUM_CH;
            if (!rr_found && pend_eff[j]) begin
                rr_found = 1'b1;
                rr_idx   = GW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wd_d    = wd_q;
        mreq_d  = 1'b0;
        mem_d   = mem_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    mreq_d  = 1'b1;
                    mem_d   = '{we: eff_we[rr_idx], addr: eff_addr[rr_idx], wdata: eff_wdata[rr_idx]};
                    last_d  = rr_idx;
                    gnt_d   = rr_idx;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    ack_d[gnt_q] = 1'b1;
                    rdata_d      = bus.mem_rdata;
                    state_d      = S_IDLE;
                end else if (wd_q == 8'(TIMEOUT)) begin
                    ack_d[gnt_q] = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                    state_d      = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= GW'(NUM_CH - 1);
            gnt_q   <= '0;
            wd_q    <= '0;
            mreq_q  <= 1'b0;
            mem_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wd_q    <= wd_d;
            mreq_q  <= mreq_d;
            mem_q   <= mem_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ch_busy   = pend;
    assign bus.ch_ack    = ack_q;
    assign bus.ch_err    = err_q;
    assign bus.ch_rdata  = rdata_q;
    assign bus.overrun   = ovr;
    assign bus.mem_req   = mreq_q;
    assign bus.mem_we    = mem_q.we;
    assign bus.mem_addr  = mem_q.addr;
    assign bus.mem_wdata = mem_q.wdata;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a per-cycle vector table for reads, contention and back-to-back,
// plus hand-written sequences for overrun, timeout and reset during an access.
module tb_sdram_arbiter;
    localparam int TO = 20;
    localparam logic [21:0] A0 = 22'h000100, A1 = 22'h012345, A2 = 22'h03ABCD;
    localparam logic [15:0] W0 = 16'hA000, W1 = 16'hA001, W2 = 16'hA002;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_CH(3), .ADDR_WIDTH(22), .DATA_WIDTH(16)) bus ();

    sdram_arbiter #(
        .NUM_CH(3), .ADDR_WIDTH(22), .DATA_WIDTH(16), .TIMEOUT(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req, we;
        logic        mack;
        logic [15:0] mrd;
        logic [2:0]  busy, ack;
        logic        err, mreq, mwe;
        logic [21:0] maddr;
        logic [15:0] mwd, rdata;
    } vec_t;

    vec_t tbl[64];
    int   nv = 0;

    task automatic add(input logic r, input logic [2:0] rq, input logic [2:0] w, input logic ma,
                       input logic [15:0] mrd, input logic [2:0] by, input logic [2:0] ak,
                       input logic er, input logic mr, input logic mw, input logic [21:0] mad,
                       input logic [15:0] mwd, input logic [15:0] rd);
        tbl[nv] = '{rst: r, req: rq, we: w, mack: ma, mrd: mrd, busy: by, ack: ak, err: er,
                    mreq: mr, mwe: mw, maddr: mad, mwd: mwd, rdata: rd};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int nreq, n;

    initial begin
        bus.ch_req    = '0;
        bus.ch_we     = '0;
        bus.ch_addr   = '{A2, A1, A0};
        bus.ch_wdata  = '{W2, W1, W0};
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();

        // single read on ch1
        add(1, 3'b000, 0, 0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b010, 0, 0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0, 0, 0,        3'b010, 3'b000, 0, 1, 0, A1, W1, 0);
        add(0, 3'b000, 0, 0, 0,        3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0, 0, 0,        3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0, 0, 0,        3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0, 1, 16'hBEEF, 3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0, 0, 0,        3'b000, 3'b010, 0, 0, 0, 0,  0,  16'hBEEF);
        add(0, 3'b000, 0, 0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        // contention: all three at once, ch2 is a write
        add(1, 3'b000, 0,      0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b111, 3'b100, 0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b111, 3'b000, 0, 1, 0, A0, W0, 0);
        add(0, 3'b000, 0,      0, 0,        3'b111, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b111, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      1, 16'h1111, 3'b111, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b001, 0, 0, 0, 0,  0,  16'h1111);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b000, 0, 1, 0, A1, W1, 0);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      1, 16'h2222, 3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b100, 3'b010, 0, 0, 0, 0,  0,  16'h2222);
        add(0, 3'b000, 0,      0, 0,        3'b100, 3'b000, 0, 1, 1, A2, W2, 0);
        add(0, 3'b000, 0,      0, 0,        3'b100, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b100, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      1, 16'h3333, 3'b100, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b000, 3'b100, 0, 0, 0, 0,  0,  16'h3333);
        // ch2 requests before ch1
        add(0, 3'b100, 0,      0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b010, 0,      0, 0,        3'b100, 3'b000, 0, 1, 0, A2, W2, 0);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      1, 16'h4444, 3'b110, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b010, 3'b100, 0, 0, 0, 0,  0,  16'h4444);
        add(0, 3'b000, 0,      0, 0,        3'b010, 3'b000, 0, 1, 0, A1, W1, 0);
        add(0, 3'b000, 0,      0, 0,        3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      1, 16'h5555, 3'b010, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b000, 3'b010, 0, 0, 0, 0,  0,  16'h5555);
        // back-to-back on ch0: re-request in the ack cycle
        add(0, 3'b001, 0,      0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b001, 3'b000, 0, 1, 0, A0, W0, 0);
        add(0, 3'b000, 0,      1, 16'h6666, 3'b001, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b001, 0,      0, 0,        3'b000, 3'b001, 0, 0, 0, 0,  0,  16'h6666);
        add(0, 3'b000, 0,      0, 0,        3'b001, 3'b000, 0, 1, 0, A0, W0, 0);
        add(0, 3'b000, 0,      1, 16'h7777, 3'b001, 3'b000, 0, 0, 0, 0,  0,  0);
        add(0, 3'b000, 0,      0, 0,        3'b000, 3'b001, 0, 0, 0, 0,  0,  16'h7777);
        add(0, 3'b000, 0,      0, 0,        3'b000, 3'b000, 0, 0, 0, 0,  0,  0);

        for (int v = 0; v < nv; v++) begin
            rst           = tbl[v].rst;
            bus.ch_req    = tbl[v].req;
            bus.ch_we     = tbl[v].we;
            bus.mem_ack   = tbl[v].mack;
            bus.mem_rdata = tbl[v].mrd;
            if (!tbl[v].rst) begin
                chk($sformatf("v%0d busy", v), 32'(bus.ch_busy), 32'(tbl[v].busy));
                chk($sformatf("v%0d ack", v), 32'(bus.ch_ack), 32'(tbl[v].ack));
                chk($sformatf("v%0d err", v), 32'(bus.ch_err), 32'(tbl[v].err));
                chk($sformatf("v%0d mem_req", v), 32'(bus.mem_req), 32'(tbl[v].mreq));
                chk($sformatf("v%0d overrun", v), 32'(bus.overrun), 32'd0);
                if (tbl[v].mreq) begin
                    chk($sformatf("v%0d mem_we", v), 32'(bus.mem_we), 32'(tbl[v].mwe));
                    chk($sformatf("v%0d mem_addr", v), 32'(bus.mem_addr), 32'(tbl[v].maddr));
                    chk($sformatf("v%0d mem_wdata", v), 32'(bus.mem_wdata), 32'(tbl[v].mwd));
                end
                if (tbl[v].ack != 3'b000)
                    chk($sformatf("v%0d rdata", v), 32'(bus.ch_rdata), 32'(tbl[v].rdata));
            end
            tick();
        end
        bus.ch_req  = '0;
        bus.ch_we   = '0;
        bus.mem_ack = 1'b0;

        // reset values of the registered bus outputs
        do_reset();
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst ch_rdata", 32'(bus.ch_rdata), 32'd0);

        // overrun: second ch0 pulse while busy is dropped
        nreq = 0;
        bus.ch_req = 3'b001;
        tick(); nreq += int'(bus.mem_req);
        bus.ch_req = 3'b000;
        tick(); nreq += int'(bus.mem_req);
        bus.ch_req = 3'b001;
        tick(); nreq += int'(bus.mem_req);
        bus.ch_req = 3'b000;
        chk("ovr set", 32'(bus.overrun), 32'b001);
        tick(); nreq += int'(bus.mem_req);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h0F0F;
        tick(); nreq += int'(bus.mem_req);
        bus.mem_ack = 1'b0;
        chk("ovr ack", 32'(bus.ch_ack), 32'b001);
        for (int c = 0; c < 4; c++) begin
            tick(); nreq += int'(bus.mem_req);
        end
        chk("ovr mem_req count", 32'(nreq), 32'd1);
        chk("ovr sticky", 32'(bus.overrun), 32'b001);
        do_reset();
        chk("ovr cleared", 32'(bus.overrun), 32'b000);

        // timeout on ch2, with junk on mem_rdata
        bus.mem_rdata = 16'hFFFF;
        bus.ch_req = 3'b100;
        tick();
        bus.ch_req = 3'b000;
        chk("to mem_req", 32'(bus.mem_req), 32'd1);
        n = 0;
        for (int c = 1; c <= TO + 5; c++) begin
            tick();
            if (bus.ch_ack != 3'b000) begin
                n = c;
                break;
            end
        end
        chk("to latency", 32'(n), 32'(TO + 1));
        chk("to ack", 32'(bus.ch_ack), 32'b100);
        chk("to err", 32'(bus.ch_err), 32'd1);
        chk("to rdata", 32'(bus.ch_rdata), 32'd0);
        chk("to busy", 32'(bus.ch_busy), 32'b000);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("late ack c%0d", c), 32'({bus.ch_ack, bus.ch_err, bus.mem_req}), 32'd0);
            tick();
        end

        // reset while waiting for the controller
        bus.ch_req = 3'b010;
        tick();
        bus.ch_req = 3'b000;
        chk("rw mem_req", 32'(bus.mem_req), 32'd1);
        tick();
        tick();
        do_reset();
        chk("rw busy", 32'(bus.ch_busy), 32'b000);
        chk("rw ack", 32'(bus.ch_ack), 32'b000);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h1234;
        tick();
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rw idle c%0d", c), 32'({bus.ch_busy, bus.ch_ack, bus.mem_req}), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
